// File: rtl/corefifo_wr_ptr_ctrl.sv
// Write-side pointer/flag controller for CoreFIFO; flags and Gray pointer registered, 1 clk after write.
// Writes while full are dropped (memwe=0); optional sticky overflow under `COREFIFO_WR_OVERFLOW_EN.
module corefifo_wr_ptr_ctrl #(
  parameter int ADDRWIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we,
  input  logic [ADDRWIDTH:0]   rptr_gray_sync,
  output logic                 memwe,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic [ADDRWIDTH:0]   wptr_gray,
  output logic                 wfull,
  output logic                 wafull,
  output logic [ADDRWIDTH:0]   wcount,
  output logic                 overflow
);

  localparam int PW = ADDRWIDTH + 1;
  localparam logic [ADDRWIDTH:0] DEPTH_P  = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH:0] THRESH_P = PW'(AFULL_THRESH);

  logic [ADDRWIDTH:0] wbin;
  logic [ADDRWIDTH:0] wbin_next;
  logic [ADDRWIDTH:0] rbin;
  logic [ADDRWIDTH:0] cnt_next;
  logic               acc;

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(rptr_gray_sync >> i);
    end
  end

  // Gated by rstn so the RAM never sees a write while the pointer is held in reset.
  assign memwe     = we & ~wfull & rstn;
  assign acc       = memwe;
  assign wbin_next = wbin + {{ADDRWIDTH{1'b0}}, acc};
  assign cnt_next  = wbin_next - rbin;
  assign waddr     = wbin[ADDRWIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wbin      <= '0;
      wptr_gray <= '0;
      wcount    <= '0;
      wfull     <= 1'b0;
      wafull    <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wptr_gray <= wbin_next ^ (wbin_next >> 1);
      wcount    <= cnt_next;
      wfull     <= (cnt_next == DEPTH_P);
      wafull    <= (cnt_next >= THRESH_P);
    end
  end

`ifdef COREFIFO_WR_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else if (we && wfull) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_corefifo_wr_ptr_ctrl.sv
// Directed bench for corefifo_wr_ptr_ctrl (ADDRWIDTH=3, AFULL_THRESH=6).
module tb_corefifo_wr_ptr_ctrl;

`ifdef COREFIFO_WR_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       we;
  logic [3:0] rptr_gray_sync;
  logic       memwe;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       wfull;
  logic       wafull;
  logic [3:0] wcount;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  corefifo_wr_ptr_ctrl #(.ADDRWIDTH(3), .AFULL_THRESH(6)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .we             (we),
    .rptr_gray_sync (rptr_gray_sync),
    .memwe          (memwe),
    .waddr          (waddr),
    .wptr_gray      (wptr_gray),
    .wfull          (wfull),
    .wafull         (wafull),
    .wcount         (wcount),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic       we;
    logic [3:0] rg;
    logic       chk_pre;
    logic       memwe;
    logic [2:0] waddr_pre;
    logic [2:0] waddr;
    logic [3:0] gray;
    logic       full;
    logic       afull;
    logic [3:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(logic r, logic w, logic [3:0] g, logic cp, logic mw,
                              logic [2:0] wp, logic [2:0] wa, logic [3:0] gy,
                              logic f, logic af, logic [3:0] c, logic o);
    vec_t v;
    v.rstn = r; v.we = w; v.rg = g; v.chk_pre = cp; v.memwe = mw;
    v.waddr_pre = wp; v.waddr = wa; v.gray = gy; v.full = f; v.afull = af;
    v.cnt = c; v.ovf = o;
    return v;
  endfunction

  function automatic logic [3:0] to_gray(logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rstn = v.rstn; we = v.we; rptr_gray_sync = v.rg;
    #1;
    if (v.chk_pre) begin
      chk($sformatf("v%0d memwe", idx), {7'd0, memwe}, {7'd0, v.memwe});
      chk($sformatf("v%0d waddr_pre", idx), {5'd0, waddr}, {5'd0, v.waddr_pre});
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d waddr", idx), {5'd0, waddr}, {5'd0, v.waddr});
    chk($sformatf("v%0d wptr_gray", idx), {4'd0, wptr_gray}, {4'd0, v.gray});
    chk($sformatf("v%0d wfull", idx), {7'd0, wfull}, {7'd0, v.full});
    chk($sformatf("v%0d wafull", idx), {7'd0, wafull}, {7'd0, v.afull});
    chk($sformatf("v%0d wcount", idx), {4'd0, wcount}, {4'd0, v.cnt});
    chk($sformatf("v%0d overflow", idx), {7'd0, overflow}, {7'd0, v.ovf & OVF_EN});
  endtask

  initial begin
    logic [3:0] gseq [8];
    logic [3:0] wb;
    logic [3:0] rb;
    logic [3:0] prev_gray;
    logic [3:0] exp_cnt;
    logic [3:0] diff;

    gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    rstn = 1'b0; we = 1'b1; rptr_gray_sync = 4'h0;

    // reset with we held high
    tbl[0] = mk(0, 1, 4'h0, 0, 0, 3'd0, 3'd0, 4'h0, 0, 0, 4'd0, 0);
    tbl[1] = mk(0, 1, 4'h0, 1, 0, 3'd0, 3'd0, 4'h0, 0, 0, 4'd0, 0);
    // fill from empty: 8 writes
    for (int k = 1; k <= 8; k++) begin
      tbl[k+1] = mk(1, 1, 4'h0, 1, 1, 3'(k-1), 3'(k), gseq[k-1],
                    (k == 8), (k >= 6), 4'(k), 0);
    end
    // write while full, three cycles
    for (int k = 0; k < 3; k++) begin
      tbl[10+k] = mk(1, 1, 4'h0, 1, 0, 3'd0, 3'd0, 4'hC, 1, 1, 4'd8, 1);
    end
    // release by one read, then hold
    tbl[13] = mk(1, 0, 4'h1, 1, 0, 3'd0, 3'd0, 4'hC, 0, 1, 4'd7, 1);
    tbl[14] = mk(1, 0, 4'h1, 1, 0, 3'd0, 3'd0, 4'hC, 0, 1, 4'd7, 1);
    // rbin=3 -> count 5, then reset mid-operation with we=1
    tbl[15] = mk(1, 0, 4'h2, 1, 0, 3'd0, 3'd0, 4'hC, 0, 0, 4'd5, 1);
    tbl[16] = mk(0, 1, 4'h0, 1, 0, 3'd0, 3'd0, 4'h0, 0, 0, 4'd0, 0);

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i], i);
    end

    // wrap: 20 writes, read pointer trailing so the count never exceeds 4
    wb = 4'd0;
    prev_gray = 4'h0;
    for (int n = 0; n < 20; n++) begin
      rb = (n >= 3) ? 4'(wb - 4'd3) : 4'd0;
      @(negedge clk);
      rstn = 1'b1; we = 1'b1; rptr_gray_sync = to_gray(rb);
      #1;
      chk($sformatf("wrap%0d memwe", n), {7'd0, memwe}, 8'd1);
      chk($sformatf("wrap%0d waddr", n), {5'd0, waddr}, {5'd0, wb[2:0]});
      @(posedge clk);
      #1;
      wb = wb + 4'd1;
      exp_cnt = wb - rb;
      chk($sformatf("wrap%0d wptr_gray", n), {4'd0, wptr_gray}, {4'd0, to_gray(wb)});
      diff = wptr_gray ^ prev_gray;
      chk($sformatf("wrap%0d onebit", n), {7'd0, ($countones(diff) == 1)}, 8'd1);
      chk($sformatf("wrap%0d wcount", n), {4'd0, wcount}, {4'd0, exp_cnt});
      chk($sformatf("wrap%0d wfull", n), {7'd0, wfull}, 8'd0);
      prev_gray = wptr_gray;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/corefifo_wr_ptr_ctrl.md
# corefifo_wr_ptr_ctrl

Write-side pointer controller for the CoreFIFO asynchronous FIFO. It sits in the write clock domain and keeps the binary write address for the RAM. It publishes a registered Gray-coded write pointer for the read-side double synchronizer. It consumes the read pointer after that pointer has been double-synchronized into this domain, and from it derives full, almost-full, fill count and an optional overflow flag.

## Interface
Parameters:
- ADDRWIDTH, 3, RAM address width; FIFO depth DEPTH = 2**ADDRWIDTH; pointers are ADDRWIDTH+1 bits.
- AFULL_THRESH, 6, wafull asserts when fill count >= this value; legal range 1..DEPTH.

Ports:
- clk  input  1  write-domain clock; all logic on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- we  input  1  write request from the producer.
- rptr_gray_sync  input  ADDRWIDTH+1  read pointer, Gray-coded, already double-synchronized to clk.
- memwe  output  1  RAM write enable: we & ~wfull (combinational).
- waddr  output  ADDRWIDTH  RAM write address: wbin[ADDRWIDTH-1:0] (direct from register).
- wptr_gray  output  ADDRWIDTH+1  registered Gray write pointer; the only signal crossing to the read domain.
- wfull  output  1  FIFO full, registered.
- wafull  output  1  almost full, registered.
- wcount  output  ADDRWIDTH+1  fill count seen from write side, registered, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.

## Operation
- Internal state: wbin (ADDRWIDTH+1 bits, binary write pointer).
- rbin = Gray-to-binary of rptr_gray_sync. Combinational XOR prefix from the MSB down.
- Accepted write: acc = we & ~wfull. wbin_next = wbin + acc, modulo 2**(ADDRWIDTH+1).
- Fill count: cnt_next = (wbin_next - rbin) mod 2**(ADDRWIDTH+1). The result is always 0..DEPTH.
- On each clock with rstn=1, these registers load:
  - wbin <= wbin_next
  - wptr_gray <= wbin_next ^ (wbin_next >> 1)
  - wcount <= cnt_next
  - wfull <= (cnt_next == DEPTH)
  - wafull <= (cnt_next >= AFULL_THRESH)
- Write while full: the write is dropped. memwe stays 0 and wbin does not advance. overflow sets (see Configuration).
- Read-side progress only reduces the count. It becomes visible when rptr_gray_sync changes, and wfull/wcount update one clk later. The flags are therefore conservative and never under-report fullness.
- Pointer wrap: wbin wraps modulo 2**(ADDRWIDTH+1). The extra MSB distinguishes full from empty. waddr wraps modulo DEPTH.
- wptr_gray changes by exactly one bit per accepted write and does not change otherwise. No combinational path from any input to wptr_gray.

## Timing
- Reset (rstn=0 at a clk edge): wbin=0, wptr_gray=0, wcount=0, wfull=0, wafull=0, overflow=0. Consequently waddr=0 and memwe=0.
- Reset mid-operation: all state returns to the reset values on that edge, regardless of we. The read side is reset via its own rstn, as the system reset sequence already provides.
- Write latency: we=1 with wfull=0 gives memwe=1 and waddr=current address in the same cycle. After the next edge, waddr has advanced and wptr_gray, wcount and the flags reflect the write.
- Full assertion: the DEPTH-th accepted write sets wfull on the same edge that commits it. A we in the following cycle is rejected.
- Simultaneous write and read-pointer advance in one cycle: the net count is unchanged and wfull holds its previous value if it was already at that level.
- Full-flag release latency after a read: 2 read-domain cycles (the reader's Gray register plus transfer), then 2 clk (double synchronizer), then 1 clk (this block).

## Configuration
- Macro: COREFIFO_WR_OVERFLOW_EN.
- Defined: overflow register present. It sets on any edge where we=1 and wfull=1, and clears only on reset.
- Undefined: overflow is tied to constant 0 and no register is synthesized. All other behaviour is identical.

## Test plan
Parameters for all scenarios: ADDRWIDTH=3, AFULL_THRESH=6.
- Reset check: drive rstn=0 for 2 edges with we=1 → all outputs 0, memwe=0 during reset.
- Fill from empty, rptr_gray_sync=0: 8 consecutive we → waddr steps 0..7; wptr_gray sequence 1,3,2,6,7,5,4,C; wafull=1 after the 6th write; wfull=1 and wcount=8 after the 8th.
- Write while full: we=1 for 3 cycles at wfull=1 → memwe=0, wbin unchanged, wptr_gray=C. overflow=1 with COREFIFO_WR_OVERFLOW_EN and stays 1; overflow=0 without the macro.
- Release: from full, set rptr_gray_sync=1 (rbin=1) → wcount=7 and wfull=0 one edge later; wafull stays 1.
- Wrap: with rptr_gray_sync tracking to keep count at 4 or below, perform 20 writes → waddr wraps 7→0; wptr_gray wraps from 8 (binary 15) to 0 (binary 0); one bit changes per write throughout.
- Mid-operation reset: assert rstn=0 at wcount=5 with we=1 → next edge shows all outputs 0.
